// File: rtl/rst_seq_gen.sv
// Staged multi-domain reset sequencer with debounced switch, software and
// optional watchdog (RST_WDT_EN) sources; reports last cause and chip_ready.
module rst_seq_gen #(
  parameter int NUM_DOMAINS     = 4,
  parameter int POR_CYCLES      = 32,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_sw,
  input  logic                   sw_reset_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] domain_reset_,
  output logic                   chip_ready,
  output logic [1:0]             reset_cause
);

  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    S_POR, S_HOLD, S_RELEASE, S_RUN
  } state_t;

  state_t          state;
  logic [PW-1:0]   por_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   idx;
  logic            sync1;
  logic            sync2;
  logic [DW-1:0]   deb_cnt;
  logic            sw_trig;
  logic            sw_level;
  logic            wdt_trig;
  logic            trig;
  logic [1:0]      cause_nxt;

  // Synchronise the raw switch and count consecutive high cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= reset_sw;
      sync2 <= sync1;
      if (!sync2)
        deb_cnt <= '0;
      else if (deb_cnt != DW'(DEBOUNCE_CYCLES - 1))
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign sw_trig  = sync2 && (deb_cnt == DW'(DEBOUNCE_CYCLES - 2));
  assign sw_level = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

`ifdef RST_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_cnt;

  // Watchdog runs only while the chip is up; a kick or leaving RUN clears it.
  always_ff @(posedge clk) begin
    if (reset || state != S_RUN || wdt_kick)
      wdt_cnt <= '0;
    else if (wdt_cnt != WW'(WDT_CYCLES - 1))
      wdt_cnt <= wdt_cnt + 1'b1;
  end

  assign wdt_trig = (state == S_RUN) && !wdt_kick &&
                    (wdt_cnt == WW'(WDT_CYCLES - 1));
`else
  logic wdt_unused;
  assign wdt_unused = wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_trig   = 1'b0;
`endif

  assign trig = sw_trig | wdt_trig | sw_reset_req;

  // Switch outranks watchdog, which outranks software.
  always_comb begin
    cause_nxt = 2'b10;
    if (sw_trig)
      cause_nxt = 2'b01;
    else if (wdt_trig)
      cause_nxt = 2'b11;
  end

  // Sequencer: POR wait, hold after trigger, staged release, run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_POR;
      por_cnt       <= '0;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      idx           <= '0;
      domain_reset_ <= '0;
      chip_ready    <= 1'b0;
      reset_cause   <= 2'b00;
    end else begin
      unique case (state)
        S_POR: begin
          if (por_cnt == PW'(POR_CYCLES - 1)) begin
            state   <= S_RELEASE;
            por_cnt <= '0;
            idx     <= '0;
            gap_cnt <= '0;
          end else begin
            por_cnt <= por_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (trig) begin
            hold_cnt    <= '0;
            reset_cause <= cause_nxt;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            if (!sw_level) begin
              state    <= S_RELEASE;
              hold_cnt <= '0;
              idx      <= '0;
              gap_cnt  <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (trig) begin
            state         <= S_HOLD;
            hold_cnt      <= '0;
            domain_reset_ <= '0;
            chip_ready    <= 1'b0;
            reset_cause   <= cause_nxt;
          end else if (gap_cnt == GW'(STAGE_GAP - 1)) begin
            domain_reset_[idx] <= 1'b1;
            gap_cnt            <= '0;
            if (idx == IW'(NUM_DOMAINS - 1))
              state <= S_RUN;
            else
              idx <= idx + 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (trig) begin
            state         <= S_HOLD;
            hold_cnt      <= '0;
            domain_reset_ <= '0;
            chip_ready    <= 1'b0;
            reset_cause   <= cause_nxt;
          end else begin
            chip_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: POR timing, software, switch, abort,
// priority, mid-sequence reset and watchdog behaviour.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_sw = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic [3:0] domain_reset_;
  logic       chip_ready;
  logic [1:0] reset_cause;

  int   checks = 0;
  int   errors = 0;
  int   ec = 0;
  int   s;
  logic drop;
  logic exp_drop;
  logic [1:0] exp_cause;

  always #5 clk = ~clk;

  rst_seq_gen #(.WDT_CYCLES(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .reset_sw      (reset_sw),
    .sw_reset_req  (sw_reset_req),
    .wdt_kick      (wdt_kick),
    .domain_reset_ (domain_reset_),
    .chip_ready    (chip_ready),
    .reset_cause   (reset_cause)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic run_to(input int t);
    while (ec < t) step();
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_dom", domain_reset_, 4'h0);
    chk("rst_rdy", chip_ready, 1'b0);
    chk("rst_cause", reset_cause, 2'b00);
    reset = 1'b0;
    ec = 0;

    // power-on staged release
    run_to(39);  chk("por39", domain_reset_, 4'h0);
    run_to(40);  chk("por40", domain_reset_, 4'h1);
    run_to(47);  chk("por47", domain_reset_, 4'h1);
    run_to(48);  chk("por48", domain_reset_, 4'h3);
    run_to(56);  chk("por56", domain_reset_, 4'h7);
    run_to(64);  chk("por64", domain_reset_, 4'hf);
    chk("por64_rdy", chip_ready, 1'b0);
    run_to(65);  chk("por65_rdy", chip_ready, 1'b1);
    chk("por_cause", reset_cause, 2'b00);

    // software request in RUN, T = 71
    run_to(70);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk("sw_dom", domain_reset_, 4'h0);
    chk("sw_rdy", chip_ready, 1'b0);
    chk("sw_cause", reset_cause, 2'b10);
    run_to(94);  chk("sw_t23", domain_reset_, 4'h0);
    run_to(95);  chk("sw_t24", domain_reset_, 4'h1);
    run_to(119); chk("sw_t48", domain_reset_, 4'hf);
    run_to(120); chk("sw_rdy2", chip_ready, 1'b1);

    // bouncing switch never qualifies
    drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) reset_sw = ~reset_sw;
      step();
      drop |= !chip_ready;
    end
    reset_sw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      drop |= !chip_ready;
    end
    chk("bounce_drop", drop, 1'b0);
    chk("bounce_cause", reset_cause, 2'b10);

    // switch held 18 cycles -> one trigger at S+17
    s = ec;
    reset_sw = 1'b1;
    run_to(s + 16); chk("sw18_pre", chip_ready, 1'b1);
    run_to(s + 17); chk("sw18_dom", domain_reset_, 4'h0);
    chk("sw18_cause", reset_cause, 2'b01);
    run_to(s + 18);
    reset_sw = 1'b0;
    run_to(s + 40); chk("sw18_d0a", domain_reset_, 4'h0);
    run_to(s + 41); chk("sw18_d0b", domain_reset_, 4'h1);
    run_to(s + 65); chk("sw18_all", domain_reset_, 4'hf);
    run_to(s + 66); chk("sw18_rdy", chip_ready, 1'b1);

    // switch held 200 cycles keeps HOLD until released
    s = ec;
    reset_sw = 1'b1;
    run_to(s + 17);  chk("sw200_dom", domain_reset_, 4'h0);
    run_to(s + 150); chk("sw200_hold", domain_reset_, 4'h0);
    run_to(s + 200);
    reset_sw = 1'b0;
    run_to(s + 211); chk("sw200_pre", domain_reset_, 4'h0);
    run_to(s + 212); chk("sw200_d0", domain_reset_, 4'h1);
    run_to(s + 236); chk("sw200_all", domain_reset_, 4'hf);
    chk("sw200_cause", reset_cause, 2'b01);

    // abort during release at edge 50
    reset = 1'b1;
    step();
    reset = 1'b0;
    ec = 0;
    run_to(49);  chk("ab49", domain_reset_, 4'h3);
    chk("ab49_cause", reset_cause, 2'b00);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk("ab50", domain_reset_, 4'h0);
    chk("ab50_cause", reset_cause, 2'b10);
    run_to(73);  chk("ab73", domain_reset_, 4'h0);
    run_to(74);  chk("ab74", domain_reset_, 4'h1);
    run_to(98);  chk("ab98", domain_reset_, 4'hf);

    // switch and software on the same edge -> switch wins
    run_to(105);
    s = ec;
    reset_sw = 1'b1;
    run_to(s + 16);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk("pri_dom", domain_reset_, 4'h0);
    chk("pri_cause", reset_cause, 2'b01);
    run_to(s + 18);
    reset_sw = 1'b0;
    run_to(s + 17 + 33);
    chk("mid_pre", domain_reset_, 4'h3);
    chk("mid_pre_cause", reset_cause, 2'b01);

    // reset mid-release
    reset = 1'b1;
    step();
    chk("mid_dom", domain_reset_, 4'h0);
    chk("mid_rdy", chip_ready, 1'b0);
    chk("mid_cause", reset_cause, 2'b00);
    reset = 1'b0;
    ec = 0;
    run_to(39); chk("mid_por39", domain_reset_, 4'h0);
    run_to(40); chk("mid_por40", domain_reset_, 4'h1);
    run_to(65); chk("mid_rdy65", chip_ready, 1'b1);

    // kicked watchdog never fires
    drop = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wdt_kick = (i % 50 == 0);
      step();
      drop |= !chip_ready;
    end
    wdt_kick = 1'b0;
    chk("wdt_kick_drop", drop, 1'b0);

    // starved watchdog
`ifdef RST_WDT_EN
    exp_drop  = 1'b1;
    exp_cause = 2'b11;
`else
    exp_drop  = 1'b0;
    exp_cause = 2'b00;
`endif
    drop = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      drop |= !chip_ready;
    end
    chk("wdt_idle_drop", drop, exp_drop);
    chk("wdt_idle_cause", reset_cause, exp_cause);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
